// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath.
// States, opcodes, ALU codes and mux selects live here.
package mips_ctrl_pkg;

    localparam logic [2:0] RESET_STATE = 3'd0;

    typedef enum logic [2:0] {
        S_IF  = RESET_STATE,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL   = 4'd0,
        C_RTYPE = 4'd1,
        C_JR    = 4'd2,
        C_LW    = 4'd3,
        C_SW    = 4'd4,
        C_BR    = 4'd5,
        C_J     = 4'd6,
        C_JAL   = 4'd7,
        C_IMM   = 4'd8
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_SRL = 5'd6;
    localparam logic [4:0] ALU_LUI = 5'd7;

    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] SRCA_RS = 2'd0;
    localparam logic [1:0] SRCA_RT = 2'd1;
    localparam logic [1:0] SRCA_PC = 2'd2;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_SHAMT = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

endpackage

// File: rtl/instr_decode.sv
// Combinational op/funct decode into an instruction class and the
// datapath selects that go with it.
module instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [4:0] alu,
    output logic [1:0] reg_dst,
    output logic [1:0] src_a,
    output logic [1:0] src_b,
    output logic [1:0] m2r,
    output logic       ext
);

    always_comb begin
        cls     = C_ILL;
        alu     = ALU_ADD;
        reg_dst = REGDST_RT;
        src_a   = SRCA_RS;
        src_b   = SRCB_REG;
        m2r     = M2R_ALU;
        ext     = 1'b1;
        unique case (op)
            OP_RTYPE: begin
                reg_dst = REGDST_RD;
                cls     = C_RTYPE;
                unique case (funct)
                    FN_ADD: alu = ALU_ADD;
                    FN_SUB: alu = ALU_SUB;
                    FN_AND: alu = ALU_AND;
                    FN_OR:  alu = ALU_OR;
                    FN_SLT: alu = ALU_SLT;
                    FN_SLL: begin
                        alu   = ALU_SLL;
                        src_a = SRCA_RT;
                        src_b = SRCB_SHAMT;
                    end
                    FN_SRL: begin
                        alu   = ALU_SRL;
                        src_a = SRCA_RT;
                        src_b = SRCB_SHAMT;
                    end
                    FN_JR:  cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_LW: begin
                cls   = C_LW;
                src_b = SRCB_IMM;
                m2r   = M2R_MEM;
            end
            OP_SW: begin
                cls   = C_SW;
                src_b = SRCB_IMM;
            end
            OP_BEQ, OP_BNE: begin
                cls = C_BR;
                alu = ALU_SUB;
            end
            OP_J: cls = C_J;
            OP_JAL: begin
                cls     = C_JAL;
                reg_dst = REGDST_R31;
                src_a   = SRCA_PC;
                m2r     = M2R_PC4;
            end
            OP_ADDI: begin
                cls   = C_IMM;
                src_b = SRCB_IMM;
            end
            OP_ORI: begin
                cls   = C_IMM;
                alu   = ALU_OR;
                src_b = SRCB_IMM;
                ext   = 1'b0;
            end
            OP_LUI: begin
                cls   = C_IMM;
                alu   = ALU_LUI;
                src_b = SRCB_IMM;
                ext   = 1'b0;
            end
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the MIPS datapath.
// Define MULTICYCLE_PERF_EN to add cycle and retire counters.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] IMEM_TIMEOUT = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        Ctrl_regWr,
    output logic        Ctrl_MemWr,
    output logic [4:0]  Ctrl_alu,
    output logic [1:0]  Ctrl_regDst,
    output logic [1:0]  Ctrl_aluSrcA,
    output logic [1:0]  Ctrl_aluSrcB,
    output logic [1:0]  Ctrl_Mem2Reg,
    output logic        Ctrl_ext,
    output logic        illegal,
    output logic        fetch_err,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt,
`endif
    output logic [2:0]  state
);

    state_t     cur, nxt;
    iclass_t    cls;
    logic [4:0] d_alu;
    logic [1:0] d_dst, d_sa, d_sb, d_m2r;
    logic       d_ext;
    logic [3:0] wait_cnt;
    logic       br_unused;

    // Branch direction is resolved in the Next_PC mux, not here.
    assign br_unused = br_taken;
    assign state     = cur;

    instr_decode u_dec (
        .op      (op),
        .funct   (funct),
        .cls     (cls),
        .alu     (d_alu),
        .reg_dst (d_dst),
        .src_a   (d_sa),
        .src_b   (d_sb),
        .m2r     (d_m2r),
        .ext     (d_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) cur <= S_IF;
        else      cur <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            fetch_err <= 1'b0;
        end else if (cur == S_IF) begin
            if (imem_ready) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt == IMEM_TIMEOUT) begin
                fetch_err <= 1'b1;
                wait_cnt  <= 4'd0;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Everything is forced low while reset is held so an aborted
    // instruction can never leak a strobe.
    always_comb begin
        nxt          = cur;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        pc_wr        = 1'b0;
        ir_wr        = 1'b0;
        Ctrl_regWr   = 1'b0;
        Ctrl_MemWr   = 1'b0;
        illegal      = 1'b0;
        Ctrl_alu     = 5'd0;
        Ctrl_regDst  = 2'd0;
        Ctrl_aluSrcA = 2'd0;
        Ctrl_aluSrcB = 2'd0;
        Ctrl_Mem2Reg = 2'd0;
        Ctrl_ext     = 1'b0;
        if (!rst) begin
            nxt = S_IF;
        end else begin
            Ctrl_alu     = d_alu;
            Ctrl_regDst  = d_dst;
            Ctrl_aluSrcA = d_sa;
            Ctrl_aluSrcB = d_sb;
            Ctrl_Mem2Reg = d_m2r;
            Ctrl_ext     = d_ext;
            unique case (cur)
                S_IF: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_wr = 1'b1;
                        nxt   = S_ID;
                    end
                end
                S_ID: begin
                    unique case (cls)
                        C_J: begin
                            pc_wr = 1'b1;
                            nxt   = S_IF;
                        end
                        C_JAL: begin
                            Ctrl_regWr = 1'b1;
                            pc_wr      = 1'b1;
                            nxt        = S_IF;
                        end
                        C_ILL: begin
                            illegal = 1'b1;
                            pc_wr   = 1'b1;
                            nxt     = S_IF;
                        end
                        default: nxt = S_EX;
                    endcase
                end
                S_EX: begin
                    unique case (cls)
                        C_BR, C_JR: begin
                            pc_wr = 1'b1;
                            nxt   = S_IF;
                        end
                        C_LW, C_SW: nxt = S_MEM;
                        default:    nxt = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        if (cls == C_SW) begin
                            Ctrl_MemWr = 1'b1;
                            pc_wr      = 1'b1;
                            nxt        = S_IF;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    Ctrl_regWr = 1'b1;
                    pc_wr      = 1'b1;
                    nxt        = S_IF;
                end
                default: nxt = S_IF;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt <= 32'd0;
            ret_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (pc_wr) ret_cnt <= ret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and strobe checks
// for each instruction class, memory stalls, reset abort and fetch timeout.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op, funct;
    logic        br_taken, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, pc_wr, ir_wr;
    logic        Ctrl_regWr, Ctrl_MemWr, Ctrl_ext, illegal, fetch_err;
    logic [4:0]  Ctrl_alu;
    logic [1:0]  Ctrl_regDst, Ctrl_aluSrcA, Ctrl_aluSrcB, Ctrl_Mem2Reg;
    logic [2:0]  state;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // strobe vector: {imem_req, ir_wr, pc_wr, regWr, MemWr, dmem_req, illegal}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] IMQ  = 7'b1000000;
    localparam logic [6:0] IRW  = 7'b0100000;
    localparam logic [6:0] PCW  = 7'b0010000;
    localparam logic [6:0] RGW  = 7'b0001000;
    localparam logic [6:0] MWR  = 7'b0000100;
    localparam logic [6:0] DMQ  = 7'b0000010;
    localparam logic [6:0] ILL  = 7'b0000001;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct        (funct),
        .br_taken     (br_taken),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_wr        (pc_wr),
        .ir_wr        (ir_wr),
        .Ctrl_regWr   (Ctrl_regWr),
        .Ctrl_MemWr   (Ctrl_MemWr),
        .Ctrl_alu     (Ctrl_alu),
        .Ctrl_regDst  (Ctrl_regDst),
        .Ctrl_aluSrcA (Ctrl_aluSrcA),
        .Ctrl_aluSrcB (Ctrl_aluSrcB),
        .Ctrl_Mem2Reg (Ctrl_Mem2Reg),
        .Ctrl_ext     (Ctrl_ext),
        .illegal      (illegal),
        .fetch_err    (fetch_err),
`ifdef MULTICYCLE_PERF_EN
        .cyc_cnt      (cyc_cnt),
        .ret_cnt      (ret_cnt),
`endif
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {imem_req, ir_wr, pc_wr, Ctrl_regWr, Ctrl_MemWr,
                dmem_req, illegal};
    endfunction

    // Check one cycle at the falling edge, then advance past the next rise.
    task automatic obs(input string tag, input logic [2:0] st,
                       input logic [6:0] sb);
        @(negedge clk);
        chk({tag, " state"}, {29'd0, state}, {29'd0, st});
        chk({tag, " strobes"}, {25'd0, strobes()}, {25'd0, sb});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [5:0] o,
                         input logic [5:0] f);
        op         = o;
        funct      = f;
        imem_ready = 1'b1;
        obs({tag, " IF"}, 3'd0, IMQ | IRW);
        imem_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        op         = 6'h00;
        funct      = 6'h20;
        br_taken   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset strobes", {25'd0, strobes()}, 32'd0);
        chk("reset fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("reset regDst", {30'd0, Ctrl_regDst}, 32'd0);
        chk("reset ext", {31'd0, Ctrl_ext}, 32'd0);
        rst = 1'b1;

        // add: IF, ID, EX, WB
        fetch("add", 6'h00, 6'h20);
        #1 chk("add regDst", {30'd0, Ctrl_regDst}, 32'd1);
        obs("add ID", 3'd1, NONE);
        obs("add EX", 3'd2, NONE);
        #1 chk("add m2r", {30'd0, Ctrl_Mem2Reg}, 32'd0);
        obs("add WB", 3'd4, RGW | PCW);

        // lw with three wait cycles in MEM
        fetch("lw", 6'h23, 6'h00);
        obs("lw ID", 3'd1, NONE);
        #1 chk("lw srcB", {30'd0, Ctrl_aluSrcB}, 32'd2);
        chk("lw ext", {31'd0, Ctrl_ext}, 32'd1);
        obs("lw EX", 3'd2, NONE);
        obs("lw MEM w1", 3'd3, DMQ);
        obs("lw MEM w2", 3'd3, DMQ);
        obs("lw MEM w3", 3'd3, DMQ);
        dmem_ready = 1'b1;
        obs("lw MEM rdy", 3'd3, DMQ);
        dmem_ready = 1'b0;
        #1 chk("lw m2r", {30'd0, Ctrl_Mem2Reg}, 32'd1);
        chk("lw regDst", {30'd0, Ctrl_regDst}, 32'd0);
        obs("lw WB", 3'd4, RGW | PCW);

        // sw zero-wait
        fetch("sw", 6'h2B, 6'h00);
        obs("sw ID", 3'd1, NONE);
        obs("sw EX", 3'd2, NONE);
        dmem_ready = 1'b1;
        obs("sw MEM", 3'd3, DMQ | MWR | PCW);
        dmem_ready = 1'b0;

        // undecoded opcode
        fetch("ill", 6'h3F, 6'h00);
        obs("ill ID", 3'd1, PCW | ILL);

        // undecoded funct
        fetch("illf", 6'h00, 6'h3F);
        obs("illf ID", 3'd1, PCW | ILL);

        fetch("j", 6'h02, 6'h00);
        obs("j ID", 3'd1, PCW);

        fetch("jal", 6'h03, 6'h00);
        #1 chk("jal regDst", {30'd0, Ctrl_regDst}, 32'd2);
        chk("jal m2r", {30'd0, Ctrl_Mem2Reg}, 32'd2);
        obs("jal ID", 3'd1, RGW | PCW);

        br_taken = 1'b1;
        fetch("beq", 6'h04, 6'h00);
        obs("beq ID", 3'd1, NONE);
        #1 chk("beq alu", {27'd0, Ctrl_alu}, 32'd1);
        obs("beq EX", 3'd2, PCW);
        br_taken = 1'b0;

        fetch("jr", 6'h00, 6'h08);
        obs("jr ID", 3'd1, NONE);
        obs("jr EX", 3'd2, PCW);

        fetch("ori", 6'h0D, 6'h00);
        #1 chk("ori ext", {31'd0, Ctrl_ext}, 32'd0);
        chk("ori alu", {27'd0, Ctrl_alu}, 32'd3);
        obs("ori ID", 3'd1, NONE);
        obs("ori EX", 3'd2, NONE);
        obs("ori WB", 3'd4, RGW | PCW);

        fetch("sll", 6'h00, 6'h00);
        #1 chk("sll srcA", {30'd0, Ctrl_aluSrcA}, 32'd1);
        chk("sll srcB", {30'd0, Ctrl_aluSrcB}, 32'd1);
        obs("sll ID", 3'd1, NONE);
        obs("sll EX", 3'd2, NONE);
        obs("sll WB", 3'd4, RGW | PCW);

        // reset asserted for two cycles mid-MEM of a store
        fetch("swr", 6'h2B, 6'h00);
        obs("swr ID", 3'd1, NONE);
        obs("swr EX", 3'd2, NONE);
        rst        = 1'b0;
        dmem_ready = 1'b1;
        #1 chk("swr rst MemWr", {31'd0, Ctrl_MemWr}, 32'd0);
        chk("swr rst pc_wr", {31'd0, pc_wr}, 32'd0);
        @(posedge clk);
        #1 chk("swr rst1 state", {29'd0, state}, 32'd0);
        chk("swr rst1 MemWr", {31'd0, Ctrl_MemWr}, 32'd0);
        @(posedge clk);
        #1 chk("swr rst2 state", {29'd0, state}, 32'd0);
        chk("swr rst2 strobes", {25'd0, strobes()}, 32'd0);
        rst        = 1'b1;
        dmem_ready = 1'b0;

        // fetch timeout: 15 waits is not enough, the 16th sets the flag
        for (int i = 0; i < 15; i++) obs("to wait", 3'd0, IMQ);
        chk("to 15 fetch_err", {31'd0, fetch_err}, 32'd0);
        obs("to wait16", 3'd0, IMQ);
        chk("to 16 fetch_err", {31'd0, fetch_err}, 32'd1);
        fetch("to j", 6'h02, 6'h00);
        obs("to j ID", 3'd1, PCW);
        chk("to sticky", {31'd0, fetch_err}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("to cleared", {31'd0, fetch_err}, 32'd0);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
